usb_desc_reader: RTL and testbench
==================================

# usb_desc_reader

Control-endpoint descriptor streamer for the USB bridge device core. It takes a decoded GET_DESCRIPTOR request (type, index, wLength) and locates the descriptor in the combinational descriptor ROM. It then reads the ROM byte by byte and emits the data stage as max-packet-size IN packets, waiting for the host handshake between packets. It sits between the SETUP decoder and the EP0 IN transmit path.

## Interface
- No parameters. Descriptor map and packet sizes are fixed constants in the shared package.
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- hs_i  in  1  high-speed link; max packet size (MPS) is 64, else 8; sampled at start_i
- start_i  in  1  one-cycle pulse: new GET_DESCRIPTOR request; ignored unless idle
- desc_type_i  in  8  wValue[15:8]
- desc_index_i  in  8  wValue[7:0]
- req_len_i  in  16  wLength
- abort_i  in  1  new SETUP or bus reset; cancels any transfer
- rom_addr_o  out  8  ROM byte address (registered)
- rom_data_i  in  8  ROM data, combinational from rom_addr_o
- tx_valid_o  out  1  beat valid
- tx_data_o  out  8  beat byte (rom_data_i passed through)
- tx_last_o  out  1  last beat of current packet
- tx_zlp_o  out  1  beat is a zero-length packet (tx_data_o don't-care, tx_last_o=1)
- tx_ready_i  in  1  beat accepted when tx_valid_o && tx_ready_i
- ack_i  in  1  pulse: host ACKed the last packet
- retry_i  in  1  pulse: packet lost (NAK/timeout); resend it
- busy_o  out  1  transfer in progress
- stall_o  out  1  one-cycle pulse: unsupported descriptor; EP0 must STALL
- done_o  out  1  one-cycle pulse: data stage complete

## Operation
- ROM map (base/len): device 0/18; configuration 18/67; string0 85/4; string1 89/30; string2 119/30; string3 149/14.
- Supported requests: type 1 (device); type 2 (configuration, index 0); type 3 (string, index 0-3). Anything else -> stall_o, stay IDLE.
- xfer_len = min(desc_len, req_len_i). Compare at 16 bits, with desc_len zero-extended.
- zlp_needed = (xfer_len < req_len_i) && (xfer_len != 0) && (xfer_len % MPS == 0).
- States: IDLE, DATA, ZLP, WAIT_ACK.
- IDLE + start_i, supported, req_len_i==0 -> done_o next cycle, stay IDLE.
- IDLE + start_i, supported, otherwise -> DATA. Latch base, xfer_len, MPS, zlp_needed. offset = pkt_start = 0.
- DATA:
  - rom_addr_o = base + offset.
  - tx_last_o = (pkt_cnt == MPS-1) || (offset == xfer_len-1).
  - On each accepted beat, offset and pkt_cnt increment.
  - On the accepted last beat -> WAIT_ACK.
- WAIT_ACK + retry_i -> offset = pkt_start, pkt_cnt = 0, back to DATA, or to ZLP if the lost packet was the ZLP.
- WAIT_ACK + ack_i:
  - offset < xfer_len -> pkt_start = offset, DATA.
  - Else if zlp_needed and ZLP not yet sent -> ZLP.
  - Else -> done_o, IDLE.
- ZLP: tx_valid_o = tx_zlp_o = tx_last_o = 1 until accepted, then WAIT_ACK.
- ack_i and retry_i together: retry_i wins.
- abort_i in any state -> IDLE next cycle. No done_o, no stall_o. A simultaneous start_i is ignored.
- ack_i, retry_i outside WAIT_ACK: ignored.

## Timing
- Reset values: every output 0, state IDLE, rom_addr_o 0.
- start_i at cycle N -> tx_valid_o with first byte at N+1.
- stall_o or done_o (zero-length request) also at N+1.
- Beats stream back-to-back at one byte per cycle while tx_ready_i is high.
- With tx_ready_i low, tx_data_o, tx_last_o and rom_addr_o hold stable.
- ack_i at cycle M -> next packet's first beat at M+1. done_o, busy_o falling and return to IDLE also occur at M+1.
- busy_o is high exactly while state != IDLE.
- Offset counters are 7 bits (xfer_len ≤ 67). pkt_cnt is 6 bits.

## Structure
- usb_desc_pkg holds:
  - descriptor type codes;
  - the ROM base/length constants;
  - MPS_FS=8 and MPS_HS=64;
  - the state enum.
- Sub-module usb_desc_lookup: combinational (type, index) -> {valid, base[7:0], len[7:0]}. It is shared with any future descriptor consumer.

## Test plan
- FS, type 1, wLength 64, tx_ready_i=1, ack after each packet -> packets of 8, 8 and 2 bytes; first bytes 12 01; no ZLP; done_o after the third ack.
- HS, type 2, wLength 255 -> 64-byte packet then 3-byte packet; byte 2 = 0x43; done_o after the second ack.
- FS, type 3 index 0, wLength 2 -> single 2-byte packet 04 03, tx_last_o on the second byte. FS, type 3 index 0, wLength 0 -> no beats, done_o at N+1.
- FS, type 3 index 2, retry_i on the second packet -> same 8 bytes resent from offset 8; random tx_ready_i backpressure preserves data order.
- Type 6, and type 3 index 4 -> stall_o pulse at N+1, no tx_valid_o, busy_o stays 0.
- abort_i mid-DATA on the HS config transfer -> IDLE next cycle, no done_o; an immediate new start_i is served normally.

Source files
------------

// File: rtl/usb_desc_reader_pkg.sv
// Shared constants and types for the EP0 descriptor streamer.
// Holds descriptor type codes, the descriptor ROM map, packet sizes,
// the streamer state enum and the lookup result payload.
package usb_desc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OFF_W  = 7;
  localparam int unsigned PKT_W  = 6;
  localparam int unsigned LEN_W  = 16;

  localparam int unsigned MPS_FS = 8;
  localparam int unsigned MPS_HS = 64;

  localparam logic [7:0] DESC_DEVICE = 8'd1;
  localparam logic [7:0] DESC_CONFIG = 8'd2;
  localparam logic [7:0] DESC_STRING = 8'd3;

  localparam logic [ADDR_W-1:0] DEV_BASE  = 8'd0;
  localparam logic [7:0]        DEV_LEN   = 8'd18;
  localparam logic [ADDR_W-1:0] CFG_BASE  = 8'd18;
  localparam logic [7:0]        CFG_LEN   = 8'd67;
  localparam logic [ADDR_W-1:0] STR0_BASE = 8'd85;
  localparam logic [7:0]        STR0_LEN  = 8'd4;
  localparam logic [ADDR_W-1:0] STR1_BASE = 8'd89;
  localparam logic [7:0]        STR1_LEN  = 8'd30;
  localparam logic [ADDR_W-1:0] STR2_BASE = 8'd119;
  localparam logic [7:0]        STR2_LEN  = 8'd30;
  localparam logic [ADDR_W-1:0] STR3_BASE = 8'd149;
  localparam logic [7:0]        STR3_LEN  = 8'd14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_ZLP      = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  // Result of a descriptor lookup: where it lives in ROM and how long it is.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
  } desc_loc_t;

endpackage

// File: rtl/usb_desc_reader_if.sv
// Request, ROM and EP0 IN transmit signals of the descriptor streamer.
// master: the streamer (usb_desc_reader); slave: SETUP decoder / ROM / TX path.
interface usb_desc_reader_if;

  logic        hs_i;
  logic        start_i;
  logic [7:0]  desc_type_i;
  logic [7:0]  desc_index_i;
  logic [15:0] req_len_i;
  logic        abort_i;
  logic [7:0]  rom_addr_o;
  logic [7:0]  rom_data_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;
  logic        tx_zlp_o;
  logic        tx_ready_i;
  logic        ack_i;
  logic        retry_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;

  modport master (
    input  hs_i, start_i, desc_type_i, desc_index_i, req_len_i, abort_i,
    input  rom_data_i, tx_ready_i, ack_i, retry_i,
    output rom_addr_o, tx_valid_o, tx_data_o, tx_last_o, tx_zlp_o,
    output busy_o, stall_o, done_o
  );

  modport slave (
    output hs_i, start_i, desc_type_i, desc_index_i, req_len_i, abort_i,
    output rom_data_i, tx_ready_i, ack_i, retry_i,
    input  rom_addr_o, tx_valid_o, tx_data_o, tx_last_o, tx_zlp_o,
    input  busy_o, stall_o, done_o
  );

endinterface

// File: rtl/usb_desc_reader_lookup.sv
// Combinational descriptor locator: (type, index) -> {valid, base, len}.
// Ports: desc_type, desc_index in; loc out (valid=0 for unsupported requests).
module usb_desc_lookup
  import usb_desc_pkg::*;
(
  input  logic [7:0] desc_type,
  input  logic [7:0] desc_index,
  output desc_loc_t  loc
);

  always_comb begin
    loc = '0;
    case (desc_type)
      DESC_DEVICE: loc = '{valid: 1'b1, base: DEV_BASE, len: DEV_LEN};
      DESC_CONFIG: begin
        if (desc_index == 8'd0) loc = '{valid: 1'b1, base: CFG_BASE, len: CFG_LEN};
      end
      DESC_STRING: begin
        case (desc_index)
          8'd0:    loc = '{valid: 1'b1, base: STR0_BASE, len: STR0_LEN};
          8'd1:    loc = '{valid: 1'b1, base: STR1_BASE, len: STR1_LEN};
          8'd2:    loc = '{valid: 1'b1, base: STR2_BASE, len: STR2_LEN};
          8'd3:    loc = '{valid: 1'b1, base: STR3_BASE, len: STR3_LEN};
          default: loc = '0;
        endcase
      end
      default: loc = '0;
    endcase
  end

endmodule

// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR data-stage streamer.
// Locates the requested descriptor, reads the ROM byte by byte and emits it
// as MPS-sized IN packets, waiting for ACK/retry between packets.
// Ports: clk_i, rst_i (async, active-high); bus (usb_desc_reader_if.master).
module usb_desc_reader
  import usb_desc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  usb_desc_reader_if.master   bus
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [OFF_W-1:0]    xfer_len_q, xfer_len_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [OFF_W-1:0]    pkt_start_q, pkt_start_d;
  logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic                hs_q, hs_d;
  logic                zlp_needed_q, zlp_needed_d;
  logic                zlp_sent_q, zlp_sent_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                done_q, done_d;
  logic                stall_q, stall_d;

  desc_loc_t           loc;
  logic [LEN_W-1:0]    desc_len16;
  logic [LEN_W-1:0]    xfer_len16;
  logic [OFF_W-1:0]    new_xfer_len;
  logic                new_zlp;
  logic [PKT_W-1:0]    mps_m1;
  logic                tx_valid_c, tx_last_c, tx_zlp_c, beat_c;

  usb_desc_lookup u_lookup (
    .desc_type  (bus.desc_type_i),
    .desc_index (bus.desc_index_i),
    .loc        (loc)
  );

  // Transfer length and ZLP requirement for an incoming request.
  // Every descriptor is at most 67 bytes, so the clamp fits OFF_W bits.
  assign desc_len16   = {8'd0, loc.len};
  assign xfer_len16   = (desc_len16 < bus.req_len_i) ? desc_len16 : bus.req_len_i;
  assign new_xfer_len = OFF_W'(xfer_len16);
  assign new_zlp      = (xfer_len16 < bus.req_len_i) && (new_xfer_len != '0) &&
                        (bus.hs_i ? (new_xfer_len[5:0] == 6'd0) : (new_xfer_len[2:0] == 3'd0));

  // Beat outputs are decoded from registered state only.
  assign mps_m1     = hs_q ? PKT_W'(MPS_HS - 1) : PKT_W'(MPS_FS - 1);
  assign tx_valid_c = (state_q == ST_DATA) || (state_q == ST_ZLP);
  assign tx_zlp_c   = (state_q == ST_ZLP);
  assign tx_last_c  = tx_zlp_c ||
                      ((state_q == ST_DATA) &&
                       ((pkt_cnt_q == mps_m1) || (offset_q == xfer_len_q - OFF_W'(1))));
  assign beat_c     = tx_valid_c && bus.tx_ready_i;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      xfer_len_q   <= '0;
      offset_q     <= '0;
      pkt_start_q  <= '0;
      pkt_cnt_q    <= '0;
      hs_q         <= 1'b0;
      zlp_needed_q <= 1'b0;
      zlp_sent_q   <= 1'b0;
      rom_addr_q   <= '0;
      done_q       <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      xfer_len_q   <= xfer_len_d;
      offset_q     <= offset_d;
      pkt_start_q  <= pkt_start_d;
      pkt_cnt_q    <= pkt_cnt_d;
      hs_q         <= hs_d;
      zlp_needed_q <= zlp_needed_d;
      zlp_sent_q   <= zlp_sent_d;
      rom_addr_q   <= rom_addr_d;
      done_q       <= done_d;
      stall_q      <= stall_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    xfer_len_d   = xfer_len_q;
    offset_d     = offset_q;
    pkt_start_d  = pkt_start_q;
    pkt_cnt_d    = pkt_cnt_q;
    hs_d         = hs_q;
    zlp_needed_d = zlp_needed_q;
    zlp_sent_d   = zlp_sent_q;
    done_d       = 1'b0;
    stall_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          if (!loc.valid) begin
            stall_d = 1'b1;
          end else if (bus.req_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_DATA;
            base_d       = loc.base;
            xfer_len_d   = new_xfer_len;
            hs_d         = bus.hs_i;
            zlp_needed_d = new_zlp;
            zlp_sent_d   = 1'b0;
            offset_d     = '0;
            pkt_start_d  = '0;
            pkt_cnt_d    = '0;
          end
        end
      end
      ST_DATA: begin
        if (beat_c) begin
          offset_d  = offset_q + OFF_W'(1);
          pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
          if (tx_last_c) state_d = ST_WAIT_ACK;
        end
      end
      ST_ZLP: begin
        if (beat_c) begin
          zlp_sent_d = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // The ZLP is always the final packet, so zlp_sent marks it as the lost one.
        if (bus.retry_i) begin
          offset_d  = pkt_start_q;
          pkt_cnt_d = '0;
          state_d   = zlp_sent_q ? ST_ZLP : ST_DATA;
        end else if (bus.ack_i) begin
          pkt_cnt_d = '0;
          if (offset_q < xfer_len_q) begin
            pkt_start_d = offset_q;
            state_d     = ST_DATA;
          end else if (zlp_needed_q && !zlp_sent_q) begin
            state_d = ST_ZLP;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      stall_d = 1'b0;
    end

    // Address tracks base + offset so it is ready the cycle a beat is presented.
    rom_addr_d = base_d + {1'b0, offset_d};
  end

  assign bus.rom_addr_o = rom_addr_q;
  assign bus.tx_valid_o = tx_valid_c;
  assign bus.tx_data_o  = bus.rom_data_i;
  assign bus.tx_last_o  = tx_last_c;
  assign bus.tx_zlp_o   = tx_zlp_c;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.stall_o    = stall_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_usb_desc_reader.sv
// Self-checking bench for usb_desc_reader: directed and random GET_DESCRIPTOR
// requests checked against a packetising reference model and a bench-side ROM.
module tb_usb_desc_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_desc_reader_if bus ();

  usb_desc_reader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] rom [0:255];
  assign bus.rom_data_i = rom[bus.rom_addr_o];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Descriptor map as seen by the host.
  function automatic void ref_lookup(input int typ, input int idx,
                                     output bit ok, output int base, output int len);
    ok = 1'b1; base = 0; len = 0;
    if (typ == 1) begin base = 0; len = 18; end
    else if (typ == 2 && idx == 0) begin base = 18; len = 67; end
    else if (typ == 3 && idx == 0) begin base = 85; len = 4; end
    else if (typ == 3 && idx == 1) begin base = 89; len = 30; end
    else if (typ == 3 && idx == 2) begin base = 119; len = 30; end
    else if (typ == 3 && idx == 3) begin base = 149; len = 14; end
    else ok = 1'b0;
  endfunction

  // One full request: stall / zero-length / streamed data stage with acks.
  task automatic run_req(input bit hs, input int typ, input int idx, input int len,
                         input int retry_pkt, input bit bp);
    bit ok, zlp, awaiting, retried, fin, hold;
    int base, dlen, xfer, mps, npk, pk, in_pkt, plen, ack_st;
    logic [7:0] h_data, h_addr;
    logic h_last;
    ref_lookup(typ, idx, ok, base, dlen);
    mps  = hs ? 64 : 8;
    xfer = (dlen < len) ? dlen : len;
    zlp  = (xfer < len) && (xfer != 0) && (xfer % mps == 0);
    npk  = (xfer + mps - 1) / mps + (zlp ? 1 : 0);
    awaiting = 0; retried = 0; fin = 0; hold = 0; pk = 0; in_pkt = 0; ack_st = 0;
    h_data = '0; h_addr = '0; h_last = 1'b0;

    @(posedge clk); #1;
    bus.hs_i = hs; bus.desc_type_i = 8'(typ); bus.desc_index_i = 8'(idx);
    bus.req_len_i = 16'(len); bus.start_i = 1'b1; bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.hs_i = !hs;
    @(negedge clk);

    if (!ok) begin
      chk("stall_pulse", bus.stall_o, 1);
      chk("stall_no_valid", bus.tx_valid_o, 0);
      chk("stall_not_busy", bus.busy_o, 0);
      @(negedge clk);
      chk("stall_one_cycle", bus.stall_o, 0);
      chk("stall_still_idle", bus.busy_o, 0);
      return;
    end
    if (len == 0) begin
      chk("zero_len_done", bus.done_o, 1);
      chk("zero_len_no_valid", bus.tx_valid_o, 0);
      chk("zero_len_not_busy", bus.busy_o, 0);
      @(negedge clk);
      chk("zero_len_done_pulse", bus.done_o, 0);
      return;
    end
    chk("first_beat_valid", bus.tx_valid_o, 1);
    chk("busy_rise", bus.busy_o, 1);

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (ack_st == 2) begin
        chk("wait_ack_idle_bus", bus.tx_valid_o, 0);
        chk("wait_ack_busy", bus.busy_o, 1);
        ack_st = 1;
      end else begin
        if (ack_st == 1) begin
          ack_st = 0;
          if (pk == npk) begin
            chk("done_after_ack", bus.done_o, 1);
            chk("busy_fall", bus.busy_o, 0);
            chk("no_valid_after_done", bus.tx_valid_o, 0);
            fin = 1;
          end else begin
            chk("no_early_done", bus.done_o, 0);
          end
        end
        if (!fin) begin
          if (!bus.tx_valid_o) begin
            chk("beat_expected", 0, 1);
            fin = 1;
          end else begin
            plen = (pk * mps + mps <= xfer) ? mps : xfer - pk * mps;
            if (plen < 0) plen = 0;
            if (hold) begin
              chk("hold_data", bus.tx_data_o, h_data);
              chk("hold_last", bus.tx_last_o, h_last);
              chk("hold_addr", bus.rom_addr_o, h_addr);
            end
            if (bus.tx_ready_i) begin
              hold = 0;
              if (plen == 0) begin
                chk("zlp_flag", bus.tx_zlp_o, 1);
                chk("zlp_last", bus.tx_last_o, 1);
              end else begin
                chk("beat_addr", bus.rom_addr_o, 32'(base + pk * mps + in_pkt));
                chk("beat_data", bus.tx_data_o, rom[base + pk * mps + in_pkt]);
                chk("beat_last", bus.tx_last_o, (in_pkt == plen - 1) ? 1 : 0);
                chk("beat_not_zlp", bus.tx_zlp_o, 0);
              end
              in_pkt++;
              if (in_pkt >= ((plen == 0) ? 1 : plen)) awaiting = 1;
            end else begin
              hold = 1;
              h_data = bus.tx_data_o; h_last = bus.tx_last_o; h_addr = bus.rom_addr_o;
            end
          end
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        bus.ack_i = 1'b0; bus.retry_i = 1'b0;
        bus.tx_ready_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (awaiting) begin
          awaiting = 0; ack_st = 2; in_pkt = 0;
          if (pk == retry_pkt && !retried) begin
            retried = 1;
            bus.retry_i = 1'b1;
            bus.ack_i = 1'($urandom_range(0, 1));
          end else begin
            bus.ack_i = 1'b1;
            pk++;
          end
        end
        @(negedge clk);
      end
    end
    if (!fin) chk("transfer_timeout", 0, 1);
    @(posedge clk); #1;
    bus.ack_i = 1'b0; bus.retry_i = 1'b0; bus.tx_ready_i = 1'b1;
  endtask

  initial begin
    int lens [14] = '{0, 1, 2, 7, 8, 9, 16, 18, 30, 64, 66, 67, 68, 255};
    int types [8] = '{1, 2, 2, 3, 3, 3, 6, 0};
    int typ, idx, len;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h12; rom[1] = 8'h01;
    rom[18] = 8'h09; rom[19] = 8'h02; rom[20] = 8'h43; rom[21] = 8'h00;
    rom[85] = 8'h04; rom[86] = 8'h03;

    rst = 1'b1;
    bus.hs_i = 1'b0; bus.start_i = 1'b0; bus.desc_type_i = '0; bus.desc_index_i = '0;
    bus.req_len_i = '0; bus.abort_i = 1'b0; bus.tx_ready_i = 1'b1;
    bus.ack_i = 1'b0; bus.retry_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.tx_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_addr", bus.rom_addr_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_last_zlp", {bus.tx_last_o, bus.tx_zlp_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", bus.busy_o, 0);

    run_req(1'b0, 1, 0, 64, -1, 1'b0);
    run_req(1'b1, 2, 0, 255, -1, 1'b0);
    run_req(1'b0, 3, 0, 2, -1, 1'b0);
    run_req(1'b0, 3, 0, 0, -1, 1'b0);
    run_req(1'b0, 3, 2, 30, 1, 1'b1);
    run_req(1'b0, 6, 0, 18, -1, 1'b0);
    run_req(1'b0, 3, 4, 18, -1, 1'b0);

    // Abort mid-DATA with a simultaneous start, then serve a new request at once.
    @(posedge clk); #1;
    bus.hs_i = 1'b1; bus.desc_type_i = 8'd2; bus.desc_index_i = 8'd0;
    bus.req_len_i = 16'd255; bus.start_i = 1'b1; bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pre_busy", bus.busy_o, 1);
    bus.abort_i = 1'b1; bus.start_i = 1'b1; bus.desc_type_i = 8'd1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.busy_o, 0);
    chk("abort_no_valid", bus.tx_valid_o, 0);
    chk("abort_no_done", bus.done_o, 0);
    chk("abort_no_stall", bus.stall_o, 0);
    run_req(1'b0, 1, 0, 64, -1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      typ = types[$urandom_range(0, 7)];
      idx = (typ == 3) ? int'($urandom_range(0, 4)) : (($urandom_range(0, 3) == 0) ? 1 : 0);
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 300)) : lens[$urandom_range(0, 13)];
      run_req(1'($urandom_range(0, 1)), typ, idx, len,
              int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
